hit_report: RTL and testbench
=============================

// Module: hit_report
// PURPOSE
//  Reports player key presses to the Cortex-M3 over APB. get_score carries CPU writes to the fabric; this block carries fabric events back to the CPU on reads.
//  Per lane: synchronise the raw button, debounce it, then turn each press (rising edge) into a timestamped event.
//  Events queue in a small FIFO. Firmware pops one event per APB read of the block's address and scores hits against tile positions.
// PARAMETERS
//  LANES     4   number of key lanes (1..8)
//  DEB_CYC   250000  stable cycles before a level change is accepted (10 ms at 25 MHz)
//  DEPTH     8   event FIFO entries (power of 2)
// PORTS
//  clk         in   1   system clock (also the APB PCLK domain)
//  res         in   1   asynchronous active-low reset
//  btn         in   LANES  raw key inputs, asynchronous, 1 = pressed
//  animate     in   1   one-cycle pulse per video frame (frame tick)
//  read_en0    in   1   APB read strobe (PSEL & PENABLE & ~PWRITE)
//  right_addr  in   1   APB address decode hit for this block
//  prdata      out  32  event word at FIFO head
//  irq         out  1   FIFO non-empty
//  overflow    out  1   sticky: an event was dropped
// BEHAVIOUR
//  Reset (res=0, asynchronous):
//   - Clears synchronisers, debounce counters, debounced levels (0), frame counter, FIFO pointers and count, and the overflow flag.
//   - irq=0; prdata=32'h0.
//  Synchroniser: 2-FF per lane; the debouncer sees btn two cycles late.
//  Debounce (per lane):
//   - Counter runs while synchronised level != debounced level; resets to 0 on equality.
//   - When counter reaches DEB_CYC-1, the debounced level takes the synchronised level and the counter clears.
//   - A level that is shorter than DEB_CYC cycles is ignored.
//  Press detect:
//   - Debounced 0->1 sets a one-cycle edge bit for that lane. Releases generate nothing.
//   - Lanes edging in the same cycle merge into one event (OR of the lane mask).
//  Frame counter: 16 bit; +1 on animate; wraps 16'hFFFF->0 silently.
//  Event word {valid, ovf, 6'b0, mask[7:0], frame[15:0]}:
//   - mask is zero-extended from LANES.
//   - frame is the counter value in the edge cycle, before any same-cycle animate increment.
//  FIFO:
//   - Push when any edge bit is set. Pop when read_en0 & right_addr & count!=0.
//   - Pointers wrap modulo DEPTH; count is 0..DEPTH.
//   - Push while full with no pop: event dropped, overflow<=1.
//   - Push and pop in the same cycle: both occur, count unchanged, no overflow, even when full.
//   - Pop when empty: no state change.
//  prdata:
//   - Combinational from the head entry, valid in the APB access phase.
//   - Non-empty: {1, overflow, 6'b0, head.mask, head.frame}.
//   - Empty: {1'b0, overflow, 30'b0}.
//   - Depends only on right_addr & state. Gated to 0 when right_addr=0 so bus muxing stays clean.
//  overflow clear: on a read (read_en0 & right_addr) that returns ovf=1, unless a drop occurs in the same cycle.
//  irq = (count!=0), registered, with a 1-cycle lag after push/pop.
//  Latency: btn edge -> FIFO entry = 2 sync + DEB_CYC + 1 (edge) + 1 (write) cycles.
// TESTING (bench uses DEB_CYC=4, DEPTH=4, LANES=4)
//  - Reset, btn=4'b0010 held at frame 5 -> after 8 cycles, irq=1 and prdata=32'h8002_0005. One read -> irq=0, prdata=32'h0.
//  - btn[0] high for 3 cycles, then low -> no event, irq stays 0.
//  - btn[3] and btn[1] rise on the same cycle -> single event with mask 8'h0A. Release generates nothing.
//  - Six presses, no reads -> 4 entries read in order, then overflow=1. The first read shows bit30=1; after that read, overflow=0.
//  - FIFO full, a press lands on the read cycle -> count stays 4, overflow stays 0, the new event is the last entry.
//  - res pulsed low mid-debounce and with 3 entries queued -> all outputs 0 at once. The first post-reset press is stamped frame 0.

Source files
------------

// File: rtl/hit_report_if.sv
// Bus bundle for hit_report: key inputs, frame tick and APB read side toward the CPU.
interface hit_report_if #(
    parameter int LANES = 4
);
    logic [LANES-1:0] btn;
    logic             animate;
    logic             read_en0;
    logic             right_addr;
    logic [31:0]      prdata;
    logic             irq;
    logic             overflow;

    modport master (
        output btn, animate, read_en0, right_addr,
        input  prdata, irq, overflow
    );

    modport slave (
        input  btn, animate, read_en0, right_addr,
        output prdata, irq, overflow
    );
endinterface

// File: rtl/hit_report.sv
// Debounces key lanes, timestamps each press with the frame count and queues
// the events in a small FIFO that firmware pops one per APB read.
module hit_report #(
    parameter int LANES   = 4,
    parameter int DEB_CYC = 250000,
    parameter int DEPTH   = 8
) (
    input  logic        clk,
    input  logic        res,
    hit_report_if.slave bus
);
    localparam int CW = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [LANES-1:0] r_sync1;
    logic [LANES-1:0] r_sync2;
    logic [LANES-1:0] r_deb;
    logic [LANES-1:0] r_debPrev;
    logic [LANES-1:0] r_edge;
    logic [CW-1:0]    r_cnt [LANES];
    logic [15:0]      r_frame;
    logic [23:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_ovf;
    logic             r_irq;

    logic [7:0]       w_maskExt;
    logic             w_push;
    logic             w_read;
    logic             w_notEmpty;
    logic             w_full;
    logic             w_pop;
    logic             w_write;
    logic             w_drop;
    logic [AW:0]      w_countNext;
    logic [23:0]      w_head;
    logic [31:0]      w_prdata;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.btn;
            r_sync2 <= r_sync1;
        end
    end

    // A lane's level is only accepted after DEB_CYC consecutive cycles of disagreement.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int i = 0; i < LANES; i++) begin
                r_cnt[i] <= '0;
            end
            r_deb <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_debPrev <= '0;
            r_edge    <= '0;
            r_frame   <= '0;
        end else begin
            r_debPrev <= r_deb;
            r_edge    <= r_deb & ~r_debPrev;
            if (bus.animate) begin
                r_frame <= r_frame + 16'd1;
            end
        end
    end

    assign w_maskExt  = 8'(r_edge);
    assign w_push     = |r_edge;
    assign w_read     = bus.read_en0 & bus.right_addr;
    assign w_notEmpty = (r_count != '0);
    assign w_full     = (r_count == CNT_FULL);
    assign w_pop      = w_read & w_notEmpty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign w_write    = w_push & (~w_full | w_pop);
    assign w_drop     = w_push & w_full & ~w_pop;

    always_comb begin
        w_countNext = r_count;
        if (w_write && !w_pop) begin
            w_countNext = r_count + 1'b1;
        end else if (w_pop && !w_write) begin
            w_countNext = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wptr] <= {w_maskExt, r_frame};
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_irq   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_write) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= w_countNext;
            r_irq   <= (w_countNext != '0);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (w_read && r_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign w_head = r_mem[r_rptr];

    always_comb begin
        w_prdata = 32'h0;
        if (bus.right_addr) begin
            if (w_notEmpty) begin
                w_prdata = {1'b1, r_ovf, 6'b0, w_head};
            end else begin
                w_prdata = {1'b0, r_ovf, 30'b0};
            end
        end
    end

    assign bus.prdata   = w_prdata;
    assign bus.irq      = r_irq;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_hit_report.sv
// Directed bench for hit_report with DEB_CYC=4, DEPTH=4, LANES=4; a press
// applied just after a clock edge reaches the FIFO eight edges later.
module tb_hit_report;
    logic        clk = 1'b0;
    logic        res = 1'b0;
    int          errors = 0;
    int          checks = 0;
    logic [15:0] expFrame = 16'h0;
    logic [31:0] got;

    always #5 clk = ~clk;

    hit_report_if #(.LANES(4)) hr();

    hit_report #(.LANES(4), .DEB_CYC(4), .DEPTH(4)) dut (
        .clk (clk),
        .res (res),
        .bus (hr)
    );

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseAnimate();
        hr.animate = 1'b1;
        tick();
        hr.animate = 1'b0;
        expFrame = expFrame + 16'd1;
    endtask

    task automatic press(input logic [3:0] m);
        hr.btn = m;
        repeat (8) tick();
        hr.btn = 4'b0;
        repeat (8) tick();
    endtask

    task automatic readEvent(output logic [31:0] data);
        hr.right_addr = 1'b1;
        hr.read_en0   = 1'b1;
        #1;
        data = hr.prdata;
        @(posedge clk);
        #1;
        hr.read_en0 = 1'b0;
    endtask

    task automatic test_reset();
        hr.btn = 4'b0; hr.animate = 1'b0; hr.read_en0 = 1'b0; hr.right_addr = 1'b1;
        res = 1'b0;
        #2;
        checks++;
        if (hr.irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", hr.irq); end
        checks++;
        if (hr.overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b expected 0", hr.overflow); end
        checks++;
        if (hr.prdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_prdata: got %h expected 00000000", hr.prdata); end
        tick(); tick();
        res = 1'b1;
        tick();
        expFrame = 16'h0;
    endtask

    task automatic test_single_press();
        repeat (5) pulseAnimate();
        hr.btn = 4'b0010;
        repeat (7) tick();
        checks++;
        if (hr.irq !== 1'b0) begin errors++; $display("[TB] FAIL latency_early_irq: got %b expected 0", hr.irq); end
        tick();
        checks++;
        if (hr.irq !== 1'b1) begin errors++; $display("[TB] FAIL latency_irq: got %b expected 1", hr.irq); end
        checks++;
        if (hr.prdata !== 32'h8002_0005) begin errors++; $display("[TB] FAIL single_prdata: got %h expected 80020005", hr.prdata); end
        hr.right_addr = 1'b0;
        #1;
        checks++;
        if (hr.prdata !== 32'h0) begin errors++; $display("[TB] FAIL prdata_gated: got %h expected 00000000", hr.prdata); end
        readEvent(got);
        checks++;
        if (got !== 32'h8002_0005) begin errors++; $display("[TB] FAIL single_read: got %h expected 80020005", got); end
        checks++;
        if (hr.irq !== 1'b0) begin errors++; $display("[TB] FAIL single_irq_after_read: got %b expected 0", hr.irq); end
        checks++;
        if (hr.prdata !== 32'h0) begin errors++; $display("[TB] FAIL empty_prdata: got %h expected 00000000", hr.prdata); end
        hr.btn = 4'b0;
        repeat (10) tick();
        checks++;
        if (hr.irq !== 1'b0) begin errors++; $display("[TB] FAIL release_silent: got %b expected 0", hr.irq); end
    endtask

    task automatic test_debounce();
        logic quiet;
        hr.btn = 4'b0001;
        repeat (3) tick();
        hr.btn = 4'b0;
        quiet = 1'b1;
        repeat (14) begin
            tick();
            if (hr.irq !== 1'b0) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin errors++; $display("[TB] FAIL short_pulse_ignored: got irq seen expected irq never set"); end
        hr.btn = 4'b0100;
        repeat (4) tick();
        hr.btn = 4'b0;
        repeat (4) tick();
        checks++;
        if (hr.irq !== 1'b1) begin errors++; $display("[TB] FAIL min_pulse_irq: got %b expected 1", hr.irq); end
        readEvent(got);
        checks++;
        if (got !== {16'h8004, expFrame}) begin errors++; $display("[TB] FAIL min_pulse_word: got %h expected %h", got, {16'h8004, expFrame}); end
        repeat (8) tick();
    endtask

    task automatic test_same_cycle();
        logic [31:0] want;
        want = {16'h800A, expFrame};
        hr.btn = 4'b1010;
        repeat (7) tick();
        pulseAnimate();
        checks++;
        if (hr.irq !== 1'b1) begin errors++; $display("[TB] FAIL merge_irq: got %b expected 1", hr.irq); end
        readEvent(got);
        checks++;
        if (got !== want) begin errors++; $display("[TB] FAIL merge_word: got %h expected %h", got, want); end
        checks++;
        if (hr.irq !== 1'b0) begin errors++; $display("[TB] FAIL merge_single_event: got %b expected 0", hr.irq); end
        hr.btn = 4'b0;
        repeat (10) tick();
        checks++;
        if (hr.irq !== 1'b0) begin errors++; $display("[TB] FAIL merge_release_silent: got %b expected 0", hr.irq); end
    endtask

    task automatic test_overflow();
        logic [31:0] exp [6];
        logic [31:0] want;
        logic [3:0]  m;
        for (int i = 0; i < 6; i++) begin
            m = 4'(1 << (i % 4));
            exp[i] = {8'h80, 4'h0, m, expFrame};
            press(m);
            pulseAnimate();
            if (i == 3) begin
                checks++;
                if (hr.overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_at_full: got %b expected 0", hr.overflow); end
            end
        end
        checks++;
        if (hr.overflow !== 1'b1) begin errors++; $display("[TB] FAIL ovf_set: got %b expected 1", hr.overflow); end
        for (int i = 0; i < 4; i++) begin
            readEvent(got);
            want = (i == 0) ? (exp[i] | 32'h4000_0000) : exp[i];
            checks++;
            if (got !== want) begin errors++; $display("[TB] FAIL ovf_read%0d: got %h expected %h", i, got, want); end
            if (i == 0) begin
                checks++;
                if (hr.overflow !== 1'b0) begin errors++; $display("[TB] FAIL ovf_clear: got %b expected 0", hr.overflow); end
            end
        end
        checks++;
        if (hr.irq !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drained_irq: got %b expected 0", hr.irq); end
        readEvent(got);
        checks++;
        if (got !== 32'h0) begin errors++; $display("[TB] FAIL pop_empty_word: got %h expected 00000000", got); end
        checks++;
        if (hr.irq !== 1'b0) begin errors++; $display("[TB] FAIL pop_empty_irq: got %b expected 0", hr.irq); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp [5];
        logic [3:0]  m;
        for (int i = 0; i < 4; i++) begin
            m = 4'(1 << (3 - i));
            exp[i] = {8'h80, 4'h0, m, expFrame};
            press(m);
            pulseAnimate();
        end
        exp[4] = {16'h8003, expFrame};
        hr.btn = 4'b0011;
        repeat (7) tick();
        hr.right_addr = 1'b1;
        hr.read_en0   = 1'b1;
        #1;
        got = hr.prdata;
        checks++;
        if (got !== exp[0]) begin errors++; $display("[TB] FAIL pushpop_head: got %h expected %h", got, exp[0]); end
        tick();
        hr.read_en0 = 1'b0;
        hr.btn      = 4'b0;
        checks++;
        if (hr.overflow !== 1'b0) begin errors++; $display("[TB] FAIL pushpop_no_ovf: got %b expected 0", hr.overflow); end
        checks++;
        if (hr.irq !== 1'b1) begin errors++; $display("[TB] FAIL pushpop_irq: got %b expected 1", hr.irq); end
        repeat (8) tick();
        for (int i = 1; i < 5; i++) begin
            readEvent(got);
            checks++;
            if (got !== exp[i]) begin errors++; $display("[TB] FAIL pushpop_read%0d: got %h expected %h", i, got, exp[i]); end
        end
        checks++;
        if (hr.irq !== 1'b0) begin errors++; $display("[TB] FAIL pushpop_drained: got %b expected 0", hr.irq); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            press(4'b0001);
            pulseAnimate();
        end
        checks++;
        if (hr.irq !== 1'b1) begin errors++; $display("[TB] FAIL queued_irq: got %b expected 1", hr.irq); end
        hr.btn = 4'b0100;
        repeat (4) tick();
        @(posedge clk);
        #3;
        res = 1'b0;
        #1;
        checks++;
        if (hr.irq !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_irq: got %b expected 0", hr.irq); end
        checks++;
        if (hr.overflow !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_ovf: got %b expected 0", hr.overflow); end
        checks++;
        if (hr.prdata !== 32'h0) begin errors++; $display("[TB] FAIL async_reset_prdata: got %h expected 00000000", hr.prdata); end
        hr.btn = 4'b0;
        tick(); tick();
        res = 1'b1;
        expFrame = 16'h0;
        tick();
        hr.btn = 4'b0001;
        repeat (8) tick();
        hr.btn = 4'b0;
        checks++;
        if (hr.irq !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_irq: got %b expected 1", hr.irq); end
        readEvent(got);
        checks++;
        if (got !== 32'h8001_0000) begin errors++; $display("[TB] FAIL post_reset_word: got %h expected 80010000", got); end
        checks++;
        if (hr.irq !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_empty: got %b expected 0", hr.irq); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_debounce();
        test_same_cycle();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
